alarm_tone_sequencer: RTL and testbench



---
 rtl/alarm_tone_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_alarm_tone_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_tone_sequencer.sv
// ============================================================================
// Module   : alarm_tone_sequencer
// Brief    : Alarm audio back-end. Plays a fixed 8-note melody as a square
//            wave gated by a free-running 8-bit PWM carrier, on aud_pwm.
//            Optional fade-in enabled by defining ALARM_FADE_IN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alarm_tone_sequencer #(
    parameter int PRESCALE = 100,     // clock cycles per tone tick
    parameter int NOTE_LEN = 250000,  // tone ticks per melody note
    parameter int REPEATS  = 0        // melody loops per start, 0 = forever
) (
    input  logic       pclk_i,
    input  logic       prst_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic [7:0] volume_i,
    output logic       busy_o,
    output logic [2:0] note_idx_o,
    output logic       aud_pwm
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int c_PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_DW = $clog2(NOTE_LEN + 1);
    localparam int c_LW = (REPEATS > 0) ? $clog2(REPEATS + 1) : 1;

    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(PRESCALE - 1);
    localparam logic [c_DW-1:0] c_DUR_LAST   = c_DW'(NOTE_LEN - 1);
    localparam logic [c_LW-1:0] c_LOOP_LAST  = c_LW'(REPEATS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    // Melody ROM: tone half-periods in ticks, 0 marks a rest
    function automatic logic [9:0] f_half_period(input logic [2:0] idx);
        logic [9:0] v;
        case (idx)
            3'd0, 3'd2, 3'd4, 3'd6: v = 10'd568;
            3'd1, 3'd5:             v = 10'd759;
            default:                v = 10'd0;
        endcase
        return v;
    endfunction

    state_t          r_state;
    state_t          w_state_next;
    logic [c_PW-1:0] r_presc;
    logic [9:0]      r_tone;
    logic [c_DW-1:0] r_dur;
    logic [c_LW-1:0] r_loop;
    logic [2:0]      r_idx;
    logic            r_phase;
    logic [7:0]      r_carrier;
    logic            r_pwm;

    logic            w_start_go;
    logic            w_tick;
    logic            w_note_end;
    logic            w_wrap;
    logic            w_loop_done;
    logic [9:0]      w_half;
    logic [9:0]      w_half_last;
    logic [7:0]      w_eff_vol;

    // stop_i has priority over a coincident start_i
    assign w_start_go  = (r_state == S_IDLE) && start_i && !stop_i;
    assign w_tick      = (r_state == S_PLAY) && (r_presc == c_PRESC_LAST);
    assign w_note_end  = w_tick && (r_dur == c_DUR_LAST);
    assign w_wrap      = w_note_end && (r_idx == 3'd7);
    // Only a bounded melody can run out; REPEATS == 0 loops until stopped
    assign w_loop_done = (REPEATS != 0) && w_wrap && (r_loop == c_LOOP_LAST);
    assign w_half      = f_half_period(r_idx);
    assign w_half_last = w_half - 10'd1;

    // State register
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_go) begin
                    w_state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop_i || w_loop_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Tick prescaler, tone generator, note duration and loop counting
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_presc <= '0;
            r_tone  <= '0;
            r_dur   <= '0;
            r_loop  <= '0;
            r_idx   <= '0;
            r_phase <= 1'b0;
        end else if (w_start_go) begin
            r_presc <= '0;
            r_tone  <= '0;
            r_dur   <= '0;
            r_loop  <= '0;
            r_idx   <= '0;
            r_phase <= 1'b0;
        end else if (r_state == S_PLAY) begin
            if (stop_i) begin
                // Abort: silence the tone and park the prescaler
                r_presc <= '0;
                r_tone  <= '0;
                r_dur   <= '0;
                r_phase <= 1'b0;
            end else begin
                if (r_presc == c_PRESC_LAST) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + c_PW'(1);
                end
                if (w_tick) begin
                    if (w_note_end) begin
                        // Note boundary: every note starts phase-aligned
                        r_dur   <= '0;
                        r_tone  <= '0;
                        r_phase <= 1'b0;
                        r_idx   <= r_idx + 3'd1;
                        if (w_wrap) begin
                            r_loop <= r_loop + c_LW'(1);
                        end
                    end else begin
                        r_dur <= r_dur + c_DW'(1);
                        if (w_half == 10'd0) begin
                            r_tone  <= '0;
                            r_phase <= 1'b0;
                        end else if (r_tone == w_half_last) begin
                            r_tone  <= '0;
                            r_phase <= ~r_phase;
                        end else begin
                            r_tone <= r_tone + 10'd1;
                        end
                    end
                end
            end
        end
    end

`ifdef ALARM_FADE_IN_EN
    logic [7:0] r_fade;

    // Fade-in level: cleared on start, raised by 32 per note, saturating
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_fade <= '0;
        end else if (w_start_go) begin
            r_fade <= '0;
        end else if (w_note_end && !stop_i) begin
            if (r_fade >= 8'd223) begin
                r_fade <= 8'd255;
            end else begin
                r_fade <= r_fade + 8'd32;
            end
        end
    end

    assign w_eff_vol = (r_fade < volume_i) ? r_fade : volume_i;
`else
    assign w_eff_vol = volume_i;
`endif

    // PWM carrier (free-running) and registered speaker output. Gating with
    // the next state makes aud_pwm drop in the same cycle busy_o does.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_carrier <= '0;
            r_pwm     <= 1'b0;
        end else begin
            r_carrier <= r_carrier + 8'd1;
            r_pwm     <= (w_state_next == S_PLAY) && r_phase &&
                         (r_carrier < w_eff_vol);
        end
    end

    assign busy_o     = (r_state == S_PLAY);
    assign note_idx_o = r_idx;
    assign aud_pwm    = r_pwm;

endmodule

`default_nettype wire

// File: tb/tb_alarm_tone_sequencer.sv
// ============================================================================
// Module   : tb_alarm_tone_sequencer
// Brief    : Self-checking bench for alarm_tone_sequencer (default build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alarm_tone_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop;
    logic [7:0] vol;
    logic       busy;
    logic [2:0] idx;
    logic       pwm;
    logic       start1, stop1;
    logic [7:0] vol1;
    logic       busy1;
    logic [2:0] idx1;
    logic       pwm1;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bounded melody: 2 loops of 2000-cycle notes
    alarm_tone_sequencer #(.PRESCALE(1), .NOTE_LEN(2000), .REPEATS(2)) u_dut (
        .pclk_i(clk), .prst_i(rst), .start_i(start), .stop_i(stop),
        .volume_i(vol), .busy_o(busy), .note_idx_o(idx), .aud_pwm(pwm)
    );

    // Endless melody with short notes
    alarm_tone_sequencer #(.PRESCALE(1), .NOTE_LEN(200), .REPEATS(0)) u_dut_loop (
        .pclk_i(clk), .prst_i(rst), .start_i(start1), .stop_i(stop1),
        .volume_i(vol1), .busy_o(busy1), .note_idx_o(idx1), .aud_pwm(pwm1)
    );

    // ---------------- scoreboard: busy/index change events -----------------
    typedef struct {
        int         cyc;
        logic       busy;
        logic [2:0] idx;
    } ev_t;
    ev_t exp_ev_q[$];
    ev_t obs_ev_q[$];
    logic [3:0] prev_obs;

    always @(negedge clk) begin
        if ({busy, idx} !== prev_obs) begin
            obs_ev_q.push_back('{cyc, busy, idx});
            prev_obs = {busy, idx};
        end
    end

    // ---------------- scoreboard: PWM high counts over windows -------------
    typedef struct {
        int s;
        int e;
        int exp_n;
        int got_n;
        int id;
    } win_t;
    win_t win_q[$];
    win_t res_q[$];
    int   acc = 0;

    always @(negedge clk) begin : p_win
        win_t w;
        if (win_q.size() > 0) begin
            if (cyc >= win_q[0].s && cyc <= win_q[0].e && pwm === 1'b1) acc++;
            if (cyc >= win_q[0].e) begin
                w = win_q.pop_front();
                w.got_n = acc;
                res_q.push_back(w);
                acc = 0;
            end
        end
    end

    // ---------------- wrap counter for the endless instance ----------------
    logic [2:0] prev_idx1;
    int         wraps1 = 0;
    always @(negedge clk) begin
        if (prev_idx1 === 3'd7 && idx1 === 3'd0) wraps1++;
        prev_idx1 = idx1;
    end

    task automatic tick_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        int t;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_cmp++; if (idx !== 3'd0) begin n_bad++; $display("FAIL reset_idx actual=%0d required=0", idx); end
        n_cmp++; if (pwm !== 1'b0) begin n_bad++; $display("FAIL reset_pwm actual=%b required=0", pwm); end
        vol = 8'd255;
        t = cyc;
        start = 1'b1; @(negedge clk); start = 1'b0;
        tick_to(t + 2900);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL pre_reset_busy actual=%b required=1", busy); end
        n_cmp++; if (idx !== 3'd1) begin n_bad++; $display("FAIL pre_reset_idx actual=%0d required=1", idx); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_reset_busy actual=%b required=0", busy); end
        n_cmp++; if (idx !== 3'd0) begin n_bad++; $display("FAIL async_reset_idx actual=%0d required=0", idx); end
        n_cmp++; if (pwm !== 1'b0) begin n_bad++; $display("FAIL async_reset_pwm actual=%b required=0", pwm); end
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy actual=%b required=0", busy); end
        n_cmp++; if (idx !== 3'd0) begin n_bad++; $display("FAIL post_reset_idx actual=%0d required=0", idx); end
        n_cmp++; if (pwm !== 1'b0) begin n_bad++; $display("FAIL post_reset_pwm actual=%b required=0", pwm); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_melody();
        int t;
        ev_t e, o;
        win_t r;
        exp_ev_q.delete(); obs_ev_q.delete(); res_q.delete();
        vol = 8'd255;
        t = cyc;
        exp_ev_q.push_back('{t + 1, 1'b1, 3'd0});
        for (int n = 1; n < 16; n++) exp_ev_q.push_back('{t + 1 + 2000 * n, 1'b1, 3'(n % 8)});
        exp_ev_q.push_back('{t + 32001, 1'b0, 3'd0});
        // note 0 phase high / low, note 1 at vol 64, note 2 at vol 0, rest, note 4
        win_q.push_back('{t + 600,  t + 1111, 510, 0, 0});
        win_q.push_back('{t + 1150, t + 1650, 0,   0, 1});
        win_q.push_back('{t + 2800, t + 3311, 128, 0, 2});
        win_q.push_back('{t + 4010, t + 5990, 0,   0, 3});
        win_q.push_back('{t + 6010, t + 7990, 0,   0, 4});
        win_q.push_back('{t + 8600, t + 9111, 510, 0, 5});
        start = 1'b1; @(negedge clk); start = 1'b0;
        tick_to(t + 2700); vol = 8'd64;
        tick_to(t + 3600); vol = 8'd0;
        tick_to(t + 5995); vol = 8'd255;
        tick_to(t + 32010);
        while (exp_ev_q.size() > 0) begin
            e = exp_ev_q.pop_front();
            n_cmp++;
            if (obs_ev_q.size() == 0) begin
                n_bad++;
                $display("FAIL melody_event actual=none required=cyc%0d busy%0b idx%0d", e.cyc - t, e.busy, e.idx);
            end else begin
                o = obs_ev_q.pop_front();
                if (o.cyc !== e.cyc || o.busy !== e.busy || o.idx !== e.idx) begin
                    n_bad++;
                    $display("FAIL melody_event actual=cyc%0d busy%0b idx%0d required=cyc%0d busy%0b idx%0d",
                             o.cyc - t, o.busy, o.idx, e.cyc - t, e.busy, e.idx);
                end
            end
        end
        n_cmp++; if (obs_ev_q.size() != 0) begin n_bad++; $display("FAIL melody_extra_events actual=%0d required=0", obs_ev_q.size()); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (res_q.size() == 0) begin
                n_bad++; $display("FAIL pwm_window_%0d actual=missing required=result", i);
            end else begin
                r = res_q.pop_front();
                if (r.got_n !== r.exp_n) begin
                    n_bad++; $display("FAIL pwm_window_%0d actual=%0d high required=%0d high", r.id, r.got_n, r.exp_n);
                end
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_stop_start();
        int t;
        ev_t e, o;
        exp_ev_q.delete(); obs_ev_q.delete();
        vol = 8'd255;
        t = cyc;
        exp_ev_q.push_back('{t + 1,    1'b1, 3'd0});
        exp_ev_q.push_back('{t + 2001, 1'b1, 3'd1});
        exp_ev_q.push_back('{t + 4001, 1'b1, 3'd2});
        exp_ev_q.push_back('{t + 5001, 1'b0, 3'd2});
        start = 1'b1; @(negedge clk); start = 1'b0;
        tick_to(t + 3000);
        start = 1'b1; @(negedge clk); start = 1'b0;
        n_cmp++; if (idx !== 3'd1) begin n_bad++; $display("FAIL start_in_play_idx actual=%0d required=1", idx); end
        tick_to(t + 5000);
        stop = 1'b1; @(negedge clk); stop = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy actual=%b required=0", busy); end
        n_cmp++; if (pwm !== 1'b0) begin n_bad++; $display("FAIL stop_pwm actual=%b required=0", pwm); end
        repeat (5) @(negedge clk);
        while (exp_ev_q.size() > 0) begin
            e = exp_ev_q.pop_front();
            n_cmp++;
            if (obs_ev_q.size() == 0) begin
                n_bad++;
                $display("FAIL stop_event actual=none required=cyc%0d busy%0b idx%0d", e.cyc - t, e.busy, e.idx);
            end else begin
                o = obs_ev_q.pop_front();
                if (o.cyc !== e.cyc || o.busy !== e.busy || o.idx !== e.idx) begin
                    n_bad++;
                    $display("FAIL stop_event actual=cyc%0d busy%0b idx%0d required=cyc%0d busy%0b idx%0d",
                             o.cyc - t, o.busy, o.idx, e.cyc - t, e.busy, e.idx);
                end
            end
        end
        n_cmp++; if (obs_ev_q.size() != 0) begin n_bad++; $display("FAIL stop_extra_events actual=%0d required=0", obs_ev_q.size()); end
        // simultaneous start and stop from idle
        obs_ev_q.delete();
        start = 1'b1; stop = 1'b1; @(negedge clk); start = 1'b0; stop = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL start_stop_race_busy actual=%b required=0", busy); end
        n_cmp++; if (obs_ev_q.size() != 0) begin n_bad++; $display("FAIL start_stop_race_events actual=%0d required=0", obs_ev_q.size()); end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_loop_forever();
        int t;
        wraps1 = 0;
        vol1 = 8'd128;
        t = cyc;
        start1 = 1'b1; @(negedge clk); start1 = 1'b0;
        tick_to(t + 8300);
        n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL loop_busy actual=%b required=1", busy1); end
        n_cmp++; if (wraps1 != 5) begin n_bad++; $display("FAIL loop_wraps actual=%0d required=5", wraps1); end
        n_cmp++; if (idx1 !== 3'd1) begin n_bad++; $display("FAIL loop_idx actual=%0d required=1", idx1); end
        stop1 = 1'b1; @(negedge clk); stop1 = 1'b0;
        n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL loop_stop_busy actual=%b required=0", busy1); end
        n_cmp++; if (pwm1 !== 1'b0) begin n_bad++; $display("FAIL loop_stop_pwm actual=%b required=0", pwm1); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; vol = 8'd0;
        start1 = 1'b0; stop1 = 1'b0; vol1 = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_melody();
        test_stop_start();
        test_loop_forever();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
